// File: rtl/dual_rail_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : dual_rail_result_capture
// Description : Bridges the dual-rail ripple adder into the clocked domain.
//               Synchronises every rail, detects four-phase completion
//               (all bits valid, then all bits NULL), captures {cout, sum}
//               into a binary register offered over valid/ready, and returns
//               a four-phase acknowledge to the adder's operand source.
// Optional    : `define DR_ILLEGAL_DETECT_EN enables the sticky dr_err flag
//               for bits showing both rails high; otherwise dr_err is 0.
// Ports       : clk, rst (async, active-high)
//               sum_one/sum_zero [WIDTH], cout_one/cout_zero  - dual-rail in
//               ack_out                                       - 4-phase ack
//               res_data [WIDTH+1], res_valid, res_ready      - result out
//               dr_err                                        - illegal flag
// Revision    : 1.0 - initial release
// ============================================================================
module dual_rail_result_capture #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,  // minimum 2
  parameter int STABLE_CYCLES = 2   // minimum 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sum_one,
  input  logic [WIDTH-1:0] sum_zero,
  input  logic             cout_one,
  input  logic             cout_zero,
  output logic             ack_out,
  output logic [WIDTH:0]   res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             dr_err
);

  localparam int N     = WIDTH + 1;
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    NULL_WAIT = 2'd0,
    PRESENT   = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Rail synchronisers: every true/false rail gets SYNC_STAGES flops.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N-1:0] sync_one;
  logic [SYNC_STAGES-1:0][N-1:0] sync_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_one  <= '0;
      sync_zero <= '0;
    end else begin
      sync_one[0]  <= {cout_one, sum_one};
      sync_zero[0] <= {cout_zero, sum_zero};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_one[i]  <= sync_one[i-1];
        sync_zero[i] <= sync_zero[i-1];
      end
    end
  end

  logic [N-1:0] one_s;
  logic [N-1:0] zero_s;
  assign one_s  = sync_one[SYNC_STAGES-1];
  assign zero_s = sync_zero[SYNC_STAGES-1];

  // A bit is valid only with exactly one rail high, so an illegal (11) bit
  // never contributes to completion.
  logic complete;
  logic all_null;
  assign complete = &(one_s ^ zero_s);
  assign all_null = ~|(one_s | zero_s);

  // --------------------------------------------------------------------------
  // Completion FSM with stability counter.
  // --------------------------------------------------------------------------
  state_t          state;
  logic [CNT_W-1:0] stab_cnt;
  logic            null_seen;
  logic            cond;
  logic            met;
  logic            change;

  always_comb begin
    cond   = (state == NULL_WAIT) ? complete : all_null;
    met    = cond && (stab_cnt == CNT_LAST);
    change = 1'b0;
    case (state)
      NULL_WAIT: change = met;
      PRESENT:   change = res_ready;  // res_valid is always 1 in PRESENT
      DRAIN:     change = met;
      default:   change = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NULL_WAIT;
      stab_cnt  <= '0;
      null_seen <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      ack_out   <= 1'b0;
    end else begin
      // Counter restarts on any state change or when the watched condition
      // drops; it saturates so a held condition stays "met".
      if (change || !cond) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_LAST) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end

      case (state)
        NULL_WAIT: begin
          if (met) begin
            res_data  <= one_s;
            res_valid <= 1'b1;
            ack_out   <= 1'b1;
            null_seen <= 1'b0;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (met) begin
            null_seen <= 1'b1;
          end
          if (res_ready) begin
            res_valid <= 1'b0;
            null_seen <= 1'b0;
            // Return-to-zero already observed: release the adder right away.
            if (null_seen || met) begin
              ack_out <= 1'b0;
              state   <= NULL_WAIT;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (met) begin
            ack_out <= 1'b0;
            state   <= NULL_WAIT;
          end
        end
        default: begin
          res_valid <= 1'b0;
          ack_out   <= 1'b0;
          null_seen <= 1'b0;
          state     <= NULL_WAIT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky illegal-code detection.
  // --------------------------------------------------------------------------
`ifdef DR_ILLEGAL_DETECT_EN
  logic             illegal_any;
  logic [CNT_W-1:0] ill_cnt;
  logic             dr_err_r;

  assign illegal_any = |(one_s & zero_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_cnt  <= '0;
      dr_err_r <= 1'b0;
    end else begin
      if (!illegal_any) begin
        ill_cnt <= '0;
      end else if (ill_cnt != CNT_LAST) begin
        ill_cnt <= ill_cnt + CNT_W'(1);
      end
      if (illegal_any && (ill_cnt == CNT_LAST)) begin
        dr_err_r <= 1'b1;
      end
    end
  end

  assign dr_err = dr_err_r;
`else
  assign dr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_rail_result_capture
// Description : Self-checking bench for dual_rail_result_capture. Expected
//               results are queued when a wavefront is driven and compared
//               when the consumer handshake takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_rail_result_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sum_one, sum_zero;
  logic         cout_one, cout_zero;
  logic         ack_out;
  logic [W:0]   res_data;
  logic         res_valid;
  logic         res_ready;
  logic         dr_err;

  int         compared   = 0;
  int         mismatched = 0;
  logic [W:0] exp_q[$];
  logic [W:0] sb_exp;

  dual_rail_result_capture #(
    .WIDTH(W), .SYNC_STAGES(2), .STABLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .sum_one(sum_one), .sum_zero(sum_zero),
    .cout_one(cout_one), .cout_zero(cout_zero),
    .ack_out(ack_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .dr_err(dr_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake seen at the falling edge is taken at the next
  // rising edge, so the data must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard: unexpected result %h, none expected", res_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (res_data !== sb_exp) begin
          mismatched++;
          $display("FAIL scoreboard: res_data %h, expected %h", res_data, sb_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input logic [W:0] ones, input logic [W:0] zeros);
    {cout_one, sum_one}   = ones;
    {cout_zero, sum_zero} = zeros;
  endtask

  task automatic drive(input logic [W:0] v);
    drive_bits(v, ~v);
  endtask

  task automatic set_null();
    drive_bits('0, '0);
  endtask

  task automatic wait_valid(input int max, output int edges);
    edges = -1;
    for (int e = 1; e <= max; e++) begin
      step(1);
      if (res_valid) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic wait_ack_low(input int max, output int edges);
    edges = -1;
    for (int e = 1; e <= max; e++) begin
      step(1);
      if (!ack_out) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    res_ready = 1'b0;
    set_null();
    step(3);
    compared++;
    if (res_valid !== 1'b0 || ack_out !== 1'b0 || res_data !== '0 || dr_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: valid=%b ack=%b data=%h err=%b, expected 0/0/000/0",
               res_valid, ack_out, res_data, dr_err);
    end
    rst = 1'b0;
    step(3);
    compared++;
    if (res_valid !== 1'b0 || ack_out !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset: valid=%b ack=%b, expected 0/0", res_valid, ack_out);
    end
  endtask

  task automatic test_capture();
    int e;
    res_ready = 1'b0;
    drive(9'h041);
    exp_q.push_back(9'h041);
    wait_valid(10, e);
    compared++;
    if (e < 4 || e > 5) begin
      mismatched++;
      $display("FAIL capture_latency: edge %0d, expected 4..5", e);
    end
    compared++;
    if (ack_out !== 1'b1 || res_data !== 9'h041) begin
      mismatched++;
      $display("FAIL capture_data: ack=%b data=%h, expected 1/041", ack_out, res_data);
    end
  endtask

  task automatic test_backpressure();
    int e;
    set_null();
    for (int i = 0; i < 20; i++) begin
      step(1);
      compared++;
      if (res_valid !== 1'b1 || ack_out !== 1'b1 || res_data !== 9'h041) begin
        mismatched++;
        $display("FAIL backpressure_hold cyc %0d: valid=%b ack=%b data=%h, expected 1/1/041",
                 i, res_valid, ack_out, res_data);
      end
    end
    res_ready = 1'b1;
    step(1);
    compared++;
    if (res_valid !== 1'b0 || ack_out !== 1'b0 || res_data !== 9'h041) begin
      mismatched++;
      $display("FAIL backpressure_release: valid=%b ack=%b data=%h, expected 0/0/041",
               res_valid, ack_out, res_data);
    end
  endtask

  task automatic test_overflow();
    int e;
    res_ready = 1'b1;
    drive(9'h100);
    exp_q.push_back(9'h100);
    wait_valid(10, e);
    compared++;
    if (e < 4 || e > 5) begin
      mismatched++;
      $display("FAIL overflow_latency: edge %0d, expected 4..5", e);
    end
    step(1);
    compared++;
    if (res_valid !== 1'b0 || ack_out !== 1'b1 || res_data !== 9'h100) begin
      mismatched++;
      $display("FAIL overflow_one_cycle: valid=%b ack=%b data=%h, expected 0/1/100",
               res_valid, ack_out, res_data);
    end
    step(3);
    compared++;
    if (ack_out !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_drain_ack: ack=%b, expected 1", ack_out);
    end
    set_null();
    wait_ack_low(10, e);
    compared++;
    if (e < 4 || e > 5) begin
      mismatched++;
      $display("FAIL overflow_ack_fall: edge %0d, expected 4..5", e);
    end
  endtask

  task automatic test_staggered();
    logic [W:0] val = 9'h1A5;
    logic [W:0] ones = '0;
    logic [W:0] zeros = '0;
    int early = 0;
    int e;
    res_ready = 1'b0;
    exp_q.push_back(val);
    for (int i = 0; i <= W; i++) begin
      ones[i]  = val[i];
      zeros[i] = ~val[i];
      drive_bits(ones, zeros);
      step(1);
      if (res_valid) early++;
    end
    compared++;
    if (early != 0) begin
      mismatched++;
      $display("FAIL staggered_partial: valid seen %0d times, expected 0", early);
    end
    wait_valid(10, e);
    if (e > 0) e = e + 1;  // one edge already elapsed after the last bit
    compared++;
    if (e < 4 || e > 5) begin
      mismatched++;
      $display("FAIL staggered_latency: edge %0d, expected 4..5", e);
    end
    res_ready = 1'b1;
    step(1);
    set_null();
    wait_ack_low(10, e);
    compared++;
    if (e < 0 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL staggered_ack_fall: edges %0d valid=%b, expected ack low / valid 0", e, res_valid);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_glitch();
    logic [W:0] val = 9'h0F0;
    logic [W:0] zeros;
    int early = 0;
    int e;
    res_ready = 1'b0;
    drive(val);
    step(1);
    zeros    = ~val;
    zeros[0] = 1'b0;  // bit 0 back to NULL after a single cycle
    drive_bits(val, zeros);
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (res_valid) early++;
    end
    compared++;
    if (early != 0) begin
      mismatched++;
      $display("FAIL glitch_no_capture: valid seen %0d times, expected 0", early);
    end
    drive(val);
    exp_q.push_back(val);
    wait_valid(10, e);
    compared++;
    if (e < 4 || e > 5) begin
      mismatched++;
      $display("FAIL glitch_restart_latency: edge %0d, expected 4..5", e);
    end
    res_ready = 1'b1;
    step(1);
    set_null();
    wait_ack_low(10, e);
    compared++;
    if (e < 0) begin
      mismatched++;
      $display("FAIL glitch_ack_fall: ack=%b, expected 0", ack_out);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e;
    res_ready = 1'b0;
    drive(9'h0AA);
    exp_q.push_back(9'h0AA);
    wait_valid(10, e);
    compared++;
    if (e < 4 || e > 5 || res_data !== 9'h0AA) begin
      mismatched++;
      $display("FAIL reset_mid_capture: edge %0d data=%h, expected 4..5/0AA", e, res_data);
    end
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    compared++;
    if (res_valid !== 1'b0 || ack_out !== 1'b0 || res_data !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_async: valid=%b ack=%b data=%h, expected 0/0/000",
               res_valid, ack_out, res_data);
    end
    step(2);
    rst = 1'b0;
    exp_q.push_back(9'h0AA);
    wait_valid(10, e);
    compared++;
    if (e < 4 || e > 5 || res_data !== 9'h0AA) begin
      mismatched++;
      $display("FAIL reset_mid_recapture: edge %0d data=%h, expected 4..5/0AA", e, res_data);
    end
    res_ready = 1'b1;
    step(1);
    set_null();
    wait_ack_low(10, e);
    compared++;
    if (e < 0) begin
      mismatched++;
      $display("FAIL reset_mid_ack_fall: ack=%b, expected 0", ack_out);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic exp_err;
    int early = 0;
`ifdef DR_ILLEGAL_DETECT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    res_ready = 1'b0;
    drive_bits(9'h008, 9'h008);  // bit 3 both rails high
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (res_valid) early++;
    end
    set_null();
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (res_valid || ack_out) early++;
    end
    compared++;
    if (early != 0) begin
      mismatched++;
      $display("FAIL illegal_no_capture: valid/ack seen %0d times, expected 0", early);
    end
    compared++;
    if (dr_err !== exp_err) begin
      mismatched++;
      $display("FAIL illegal_flag: dr_err=%b, expected %b", dr_err, exp_err);
    end
    step(5);
    compared++;
    if (dr_err !== exp_err) begin
      mismatched++;
      $display("FAIL illegal_sticky: dr_err=%b, expected %b", dr_err, exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_capture();
    test_backpressure();
    test_overflow();
    test_staggered();
    test_glitch();
    test_reset_mid();
    test_illegal();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d results never delivered, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dual_rail_result_capture.md
Name: dual_rail_result_capture

Overview:
- Downstream stage of the dual-rail ripple adder in the async ALU.
- Watches the WIDTH-bit dual-rail sum vector plus the dual-rail carry-out and detects four-phase completion: every bit valid, then every bit NULL.
- Captures the result into a clocked binary register, presents it to the synchronous consumer with a valid/ready handshake, and returns a four-phase acknowledge to the adder's input side.
- This block is the bridge from the clockless datapath into the clocked register file/writeback.

Parameters:
- WIDTH, 8: number of sum bits; the result is WIDTH+1 bits including carry-out.
- SYNC_STAGES, 2: synchroniser flops per rail, minimum 2.
- STABLE_CYCLES, 2: consecutive synchronised cycles a completion or NULL condition must hold before it is acted on, minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sum_one  input  WIDTH  true rails of the sum bits, asynchronous to clk.
- sum_zero  input  WIDTH  false rails of the sum bits, asynchronous to clk.
- cout_one  input  1  true rail of the carry-out.
- cout_zero  input  1  false rail of the carry-out.
- ack_out  output  1  four-phase acknowledge to the adder's operand source.
- res_data  output  WIDTH+1  captured result, {cout, sum}.
- res_valid  output  1  res_data holds an unconsumed result.
- res_ready  input  1  consumer accepts res_data.
- dr_err  output  1  sticky illegal-code flag; see Optional Feature.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - While rst is high: all synchroniser flops 0, state NULL_WAIT, counter 0, res_data 0, res_valid 0, ack_out 0, dr_err 0.
- Synchronisation:
  - Each of the 2*(WIDTH+1) rails passes through SYNC_STAGES flops.
  - All decoding uses synchronised rails only.
- Per-bit decode on synchronised rails:
  - Valid: exactly one rail high.
  - NULL: both rails low.
  - Illegal: both rails high.
  - complete: all WIDTH+1 bits valid.
  - all_null: all bits NULL.
- Counter:
  - stab_cnt increments while the condition watched by the current state holds.
  - It clears when that condition drops and on every state change.
  - The condition is met when stab_cnt reaches STABLE_CYCLES-1 with the condition still true.
- State NULL_WAIT (ack_out 0), watching complete:
  - When met, on that edge: res_data <= {cout_one_s, sum_one_s}, res_valid <= 1, ack_out <= 1, and the state goes to PRESENT.
  - Latency: for rails that all become complete simultaneously, res_valid rises on the (SYNC_STAGES+STABLE_CYCLES)th rising edge after the change, with +1 edge of synchroniser uncertainty.
- State PRESENT (res_valid 1, ack_out 1), watching all_null:
  - Latches null_seen once all_null is met.
  - On an edge where res_valid and res_ready are both high, res_valid <= 0.
  - If null_seen is set, or all_null is met on that same edge, ack_out <= 0 and the state goes to NULL_WAIT. Otherwise the state goes to DRAIN.
  - res_data is held constant for as long as res_valid is 1.
- State DRAIN (res_valid 0, ack_out 1), watching all_null:
  - When met: ack_out <= 0 and the state goes to NULL_WAIT.
- Boundary conditions:
  - A partially complete vector never captures.
  - If complete drops mid-count, the counter restarts.
  - res_ready is ignored while res_valid is 0.
  - A new data wavefront cannot be accepted until ack_out has fallen.
  - res_data keeps its last value after consumption and is only overwritten on the next capture.
  - Reset mid-operation discards the held result and drops ack_out. If rails are still at data when reset releases, a fresh capture occurs after the normal latency.

Optional Feature:
- Macro: DR_ILLEGAL_DETECT_EN.
- Defined:
  - Any synchronised bit showing illegal for STABLE_CYCLES consecutive cycles sets dr_err to 1. dr_err stays set until rst.
  - Illegal bits do not count as valid, so capture is blocked while they persist.
- Undefined:
  - dr_err is tied to 0 and there is no illegal-detect logic.
  - An illegal bit simply does not count as valid.

Test Plan:
- Capture: rails present sum 0x41, cout 0, with rails stable and all others NULL beforehand -> res_valid and ack_out rise on edge 4 (range 4-5); res_data = 0x041.
- Overflow with ready held high: 0xFF+0x01 wavefront -> res_data = 0x100; res_valid high for exactly 1 cycle; ack_out stays high until rails return to NULL for 2 synchronised cycles, then falls.
- Backpressure: res_ready low for 20 cycles while rails go NULL -> res_valid and res_data 0x041 are held; ack_out falls on the edge where res_ready is sampled high.
- Staggered rails: bits become valid one per cycle over 9 cycles -> no capture until the last bit has been stable 2 synchronised cycles; res_data is exact.
- Reset mid-PRESENT: assert rst asynchronously -> res_valid, ack_out and res_data are 0 immediately. Release with data rails still present -> recapture after normal latency.
- With DR_ILLEGAL_DETECT_EN: bit 3 with both rails high for 3 cycles -> dr_err = 1, no capture, and dr_err persists after the rails clear. Without the macro: dr_err stays 0.
